// File: rtl/cc_stream.sv
// cc_stream: frame-based sorter with a per-element recurrence and a final equation.
// A frame of NUM samples is collected into a sorted buffer. The block then steps a
// recurrence (moving average or normalization) over NUM-1 cycles and emits one result.
module cc_stream #(
   parameter int DATA_W = 4,
   parameter int NUM    = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [2:0]          opt,
   input  logic                equ,
   output logic                in_ready,
   output logic                out_valid,
   output logic [2*DATA_W+6:0] out_data
);
   localparam int M     = DATA_W + 2;
   localparam int OUT_W = 2*DATA_W + 7;
   localparam int CW    = $clog2(NUM + 1);

   localparam logic signed [M+1:0]    THREE_M = (M+2)'(3);
   localparam logic signed [OUT_W-1:0] THREE_O = OUT_W'(3);

   typedef enum logic [1:0] {IDLE, LOAD, PROC, OUT} state_t;

   state_t                state, nxt;
   logic [CW-1:0]         cnt;
   logic [2:0]            opt_q;
   logic                  equ_q;
   logic signed [M-1:0]   buf_q [NUM];
   logic signed [M-1:0]   ins   [NUM];
   logic signed [M-1:0]   r_q   [NUM];

   logic                  accept;
   logic [2:0]            cur_opt;
   logic [CW-1:0]         fill;
   logic [CW-1:0]         pos;
   logic signed [M-1:0]   sample;
   logic signed [M-1:0]   r0_val, r_prev, s_cur, r_new;
   logic                  last_beat, last_step;

   // One step of the moving average: (2*prev + s) / 3, truncating toward zero.
   function automatic logic signed [M-1:0] ma_step(input logic signed [M-1:0] prev,
                                                     input logic signed [M-1:0] s);
      logic signed [M+1:0] acc;
      logic signed [M+1:0] q;
      acc = {prev[M-1], prev, 1'b0} + {{2{s[M-1]}}, s};
      q   = acc / THREE_M;
      return q[M-1:0];
   endfunction

   // Sign-extend an element to the output width so the equation never truncates.
   function automatic logic signed [OUT_W-1:0] sx(input logic signed [M-1:0] v);
      return {{(OUT_W-M){v[M-1]}}, v};
   endfunction

   // Final equation over r0, r1 and the last three elements.
   function automatic logic signed [OUT_W-1:0] final_eq(input logic e,
                                                         input logic signed [M-1:0] a0,
                                                         input logic signed [M-1:0] a1,
                                                         input logic signed [M-1:0] b3,
                                                         input logic signed [M-1:0] b2,
                                                         input logic signed [M-1:0] b1);
      logic signed [OUT_W-1:0] p;
      if (e) begin
         p = (sx(a1) - sx(a0)) * sx(b1);
         if (p[OUT_W-1]) p = -p;
      end else begin
         p = ((sx(b3) + (sx(b2) <<< 2)) * sx(b1)) / THREE_O;
      end
      return p;
   endfunction

   assign accept    = in_valid && in_ready;
   // The first beat of a frame uses the live mode; later beats use the captured one.
   assign cur_opt   = (state == IDLE) ? opt : opt_q;
   assign fill      = (state == IDLE) ? '0 : cnt;
   assign sample    = {{(M-DATA_W){cur_opt[0] & in_data[DATA_W-1]}}, in_data};
   assign last_beat = (cnt == CW'(NUM - 1));
   assign last_step = (cnt == CW'(NUM - 1));

   // Insertion point: count of stored entries that stay ahead of the new sample (ties stay ahead).
   always_comb begin
      pos = '0;
      for (int i = 0; i < NUM; i++) begin
         if (CW'(i) < fill) begin
            if (cur_opt[1] ? (buf_q[i] >= sample) : (buf_q[i] <= sample))
               pos = pos + CW'(1);
         end
      end
   end

   // Buffer image after inserting the new sample at pos and shifting the tail down.
   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         if (CW'(i) < pos)
            ins[i] = buf_q[i];
         else if (CW'(i) == pos)
            ins[i] = sample;
         else
            ins[i] = buf_q[(i > 0) ? i - 1 : 0];
      end
   end

   assign r0_val = opt_q[2] ? buf_q[0] : '0;
   assign r_prev = (cnt == CW'(1)) ? r0_val : r_q[cnt - CW'(1)];
   assign s_cur  = buf_q[cnt];
   assign r_new  = opt_q[2] ? ma_step(r_prev, s_cur) : (s_cur - buf_q[0]);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state logic.
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (accept) nxt = LOAD;
         LOAD: if (accept && last_beat) nxt = PROC;
         PROC: if (last_step) nxt = OUT;
         OUT:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs decoded from the current state; the result is zero outside OUT.
   always_comb begin
      in_ready  = (state == IDLE) || (state == LOAD);
      out_valid = (state == OUT);
      out_data  = '0;
      if (state == OUT)
         out_data = final_eq(equ_q, r_q[0], r_q[1], r_q[NUM-3], r_q[NUM-2], r_q[NUM-1]);
   end

   // Frame capture: mode latch, beat/step counter and sorted buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         opt_q <= '0;
         equ_q <= 1'b0;
         for (int i = 0; i < NUM; i++) buf_q[i] <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               buf_q <= ins;
               cnt   <= CW'(1);
               opt_q <= opt;
               equ_q <= equ;
            end
            LOAD: if (accept) begin
               buf_q <= ins;
               cnt   <= last_beat ? CW'(1) : cnt + CW'(1);
            end
            PROC: cnt <= cnt + CW'(1);
            OUT:  cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   // Recurrence results, one element per processing cycle.
   always_ff @(posedge clk) begin
      if (state == PROC) begin
         r_q[cnt] <= r_new;
         if (cnt == CW'(1)) r_q[0] <= r0_val;
      end
   end
endmodule

// File: tb/tb_cc_stream.sv
// tb_cc_stream: directed and randomized frames checked against a queue-based reference model.
module tb_cc_stream;
   localparam int DW  = 4;
   localparam int NUM = 6;
   localparam int OW  = 2*DW + 7;

   typedef int frame_t [NUM];

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [2:0]    opt;
   logic          equ;
   logic          in_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   cc_stream #(.DATA_W(DW), .NUM(NUM)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .opt(opt), .equ(equ), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
         $error("mismatch in %s", tag);
      end
   endtask

   // Reference: stable sorted insert into a queue, then the recurrence and equation in plain ints.
   function automatic int model(input frame_t smp, input logic [2:0] o, input logic e);
      int s[$];
      int r[NUM];
      int v, j, p;
      for (int i = 0; i < NUM; i++) begin
         v = smp[i] & 15;
         if (o[0] && v >= 8) v = v - 16;
         j = 0;
         while (j < s.size() && (o[1] ? (s[j] >= v) : (s[j] <= v))) j++;
         s.insert(j, v);
      end
      r[0] = o[2] ? s[0] : 0;
      for (int k = 1; k < NUM; k++)
         r[k] = o[2] ? (2*r[k-1] + s[k]) / 3 : s[k] - s[0];
      if (e) begin
         p = (r[1] - r[0]) * r[NUM-1];
         return (p < 0) ? -p : p;
      end
      return ((r[NUM-3] + 4*r[NUM-2]) * r[NUM-1]) / 3;
   endfunction

   // Present one beat and hold it until accepted; in_valid stays high afterwards.
   task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] o, input logic e);
      int guard = 0;
      in_valid = 1'b1; in_data = d; opt = o; equ = e;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 50) check("ready_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Full frame: beats (mode scrambled after the first), busy window, result strobe, return to idle.
   task automatic run_frame(input frame_t smp, input logic [2:0] o, input logic e,
                            input bit gaps, input bit hold, input string tag, output int got);
      int expv;
      logic [OW-1:0] e15;
      expv = model(smp, o, e);
      e15  = expv[OW-1:0];
      for (int i = 0; i < NUM; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0; in_data = DW'($urandom); opt = 3'($urandom);
            @(posedge clk); #1;
         end
         if (i == 0) send_beat(DW'(smp[i]), o, e);
         else        send_beat(DW'(smp[i]), 3'($urandom), 1'($urandom));
      end
      in_valid = hold;
      for (int j = 1; j < NUM; j++) begin
         check($sformatf("%s_busy%0d", tag, j), {30'b0, out_valid, in_ready}, 32'd0);
         in_data = DW'($urandom); opt = 3'($urandom); equ = 1'($urandom);
         @(posedge clk); #1;
      end
      check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(e15));
      got = int'(out_data);
      @(posedge clk); #1;
      check({tag, "_idle"}, {15'b0, out_valid, in_ready, out_data}, {15'b0, 1'b0, 1'b1, {OW{1'b0}}});
   endtask

   initial begin
      frame_t f;
      int got;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; opt = '0; equ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {15'b0, out_valid, in_ready, out_data}, {15'b0, 1'b0, 1'b1, {OW{1'b0}}});
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_frame('{1, 2, 3, 4, 5, 6}, 3'b000, 1'b0, 1'b0, 1'b0, "norm_asc", got);
      check("norm_asc_const", got, 32'd31);
      run_frame('{1, 2, 3, 4, 5, 6}, 3'b100, 1'b0, 1'b0, 1'b0, "mavg", got);
      check("mavg_const", got, 32'd18);
      run_frame('{7, 0, 0, 0, 0, 8}, 3'b011, 1'b1, 1'b0, 1'b0, "signed_desc", got);
      check("signed_desc_const", got, 32'd105);
      run_frame('{15, 15, 15, 15, 15, 15}, 3'b101, 1'b0, 1'b0, 1'b0, "neg_ones_e0", got);
      check("neg_ones_e0_const", got, 32'd1);
      run_frame('{15, 15, 15, 15, 15, 15}, 3'b101, 1'b1, 1'b0, 1'b0, "neg_ones_e1", got);
      check("neg_ones_e1_const", got, 32'd0);

      // Back-to-back frames with in_valid never dropping.
      foreach (f[i]) f[i] = $urandom_range(0, 15);
      run_frame(f, 3'b001, 1'b0, 1'b0, 1'b1, "hold_a", got);
      foreach (f[i]) f[i] = $urandom_range(0, 15);
      run_frame(f, 3'b110, 1'b1, 1'b0, 1'b1, "hold_b", got);
      in_valid = 1'b0;

      // Reset after the third beat discards the frame.
      send_beat(4'd1, 3'b000, 1'b1);
      send_beat(4'd2, 3'b000, 1'b1);
      send_beat(4'd3, 3'b000, 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_load_state", {15'b0, out_valid, in_ready, out_data}, {15'b0, 1'b0, 1'b1, {OW{1'b0}}});
      rst_n = 1'b1;
      for (int j = 0; j < NUM + 2; j++) begin
         check($sformatf("rst_load_quiet%0d", j), {31'b0, out_valid}, 32'd0);
         @(posedge clk); #1;
      end
      run_frame('{1, 2, 3, 4, 5, 6}, 3'b000, 1'b1, 1'b0, 1'b0, "after_rst", got);
      check("after_rst_const", got, 32'd5);

      // Reset in the middle of processing.
      for (int i = 0; i < NUM; i++) send_beat(DW'($urandom), 3'b100, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_proc_state", {15'b0, out_valid, in_ready, out_data}, {15'b0, 1'b0, 1'b1, {OW{1'b0}}});
      rst_n = 1'b1;
      for (int j = 0; j < NUM + 2; j++) begin
         check($sformatf("rst_proc_quiet%0d", j), {31'b0, out_valid}, 32'd0);
         @(posedge clk); #1;
      end

      // Randomized frames with idle gaps between beats.
      for (int n = 0; n < 24; n++) begin
         foreach (f[i]) f[i] = $urandom_range(0, 15);
         run_frame(f, 3'($urandom), 1'($urandom), 1'b1, 1'b0, $sformatf("rand%0d", n), got);
      end
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
